// File: rtl/cordic_rotation_scheduler.sv
// Round-robin, credit-gated issue of angle requests into a shared pipelined
// CORDIC core, with per-requester response FIFOs fed from a tag shift pipe.
module cordic_rotation_scheduler #(
    parameter int          NREQ    = 4,
    parameter int          LATENCY = 17,
    parameter int          RDEPTH  = 4,
    parameter logic [15:0] KINIT   = 16'h136F
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [16*NREQ-1:0] req_angle,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [16*NREQ-1:0] rsp_cos,
    output logic [16*NREQ-1:0] rsp_sin,
    output logic [15:0]        core_xin,
    output logic [15:0]        core_yin,
    output logic [15:0]        core_zin,
    input  logic [15:0]        core_x0,
    input  logic [15:0]        core_y0,
    output logic               busy
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW  = $clog2(RDEPTH);
    localparam int CW  = $clog2(RDEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(RDEPTH);

    logic [CW-1:0]      used_q [NREQ];
    logic [CW-1:0]      used_d [NREQ];
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [LATENCY-1:0] tag_v_q, tag_v_d;
    logic [IDW-1:0]     tag_id_q [LATENCY];
    logic [IDW-1:0]     tag_id_d [LATENCY];
    logic [AW:0]        wptr_q [NREQ];
    logic [AW:0]        wptr_d [NREQ];
    logic [AW:0]        rptr_q [NREQ];
    logic [AW:0]        rptr_d [NREQ];
    logic [31:0]        mem_q  [NREQ][RDEPTH];

    logic [NREQ-1:0] eligible, push, pop;
    logic            gnt_any;
    logic [IDW-1:0]  gnt_id, cand_id;
    int              cand;

    always_comb begin
        for (int i = 0; i < NREQ; i++)
            eligible[i] = req_valid[i] && (used_q[i] < FULL);
    end

    // First eligible requester scanning upward from the round-robin pointer.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = 0;
        cand_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand    = (int'(ptr_q) + k) % NREQ;
            cand_id = IDW'(cand);
            if (!gnt_any && eligible[cand_id]) begin
                gnt_any = 1'b1;
                gnt_id  = cand_id;
            end
        end
        if (rst)
            gnt_any = 1'b0;
    end

    always_comb begin
        req_ready = '0;
        core_xin  = '0;
        core_yin  = '0;
        core_zin  = '0;
        ptr_d     = ptr_q;
        if (gnt_any) begin
            req_ready[gnt_id] = 1'b1;
            core_xin = KINIT;
            core_zin = req_angle[16*int'(gnt_id) +: 16];
            ptr_d    = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IDW'(1);
        end
    end

    always_comb begin
        tag_v_d     = {tag_v_q[LATENCY-2:0], gnt_any};
        tag_id_d[0] = gnt_id;
        for (int s = 1; s < LATENCY; s++)
            tag_id_d[s] = tag_id_q[s-1];
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = wptr_q[i] != rptr_q[i];
            push[i] = tag_v_q[LATENCY-1] &&
                      (int'(tag_id_q[LATENCY-1]) == i);
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            pop[i]    = rsp_valid[i] && rsp_ready[i];
            wptr_d[i] = wptr_q[i] + (AW+1)'(push[i]);
            rptr_d[i] = rptr_q[i] + (AW+1)'(pop[i]);
            used_d[i] = used_q[i] + CW'(req_ready[i]) - CW'(pop[i]);
            rsp_cos[16*i +: 16] = mem_q[i][rptr_q[i][AW-1:0]][31:16];
            rsp_sin[16*i +: 16] = mem_q[i][rptr_q[i][AW-1:0]][15:0];
        end
    end

    always_comb begin
        busy = |tag_v_q;
        for (int i = 0; i < NREQ; i++)
            if (used_q[i] != '0)
                busy = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            tag_v_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                used_q[i] <= '0;
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            tag_v_q <= tag_v_d;
            for (int i = 0; i < NREQ; i++) begin
                used_q[i] <= used_d[i];
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
            end
        end
    end

    // Tag ids and FIFO storage are qualified by valids/pointers, so no reset.
    always_ff @(posedge clk) begin
        for (int s = 0; s < LATENCY; s++)
            tag_id_q[s] <= tag_id_d[s];
        for (int i = 0; i < NREQ; i++)
            if (push[i])
                mem_q[i][wptr_q[i][AW-1:0]] <= {core_x0, core_y0};
    end
endmodule

// File: tb/tb_cordic_rotation_scheduler.sv
// Bench for cordic_rotation_scheduler: behavioural CORDIC core stand-in plus
// a queue-level reference model of arbitration, credits and response FIFOs.
module tb_cordic_rotation_scheduler;
    localparam int          NREQ   = 4;
    localparam int          LAT    = 17;
    localparam int          RDEPTH = 4;
    localparam logic [15:0] KINIT  = 16'h136F;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [16*NREQ-1:0] req_angle;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [16*NREQ-1:0] rsp_cos;
    logic [16*NREQ-1:0] rsp_sin;
    logic [15:0]        core_xin, core_yin, core_zin;
    logic [15:0]        core_x0, core_y0;
    logic               busy;

    cordic_rotation_scheduler #(
        .NREQ(NREQ), .LATENCY(LAT), .RDEPTH(RDEPTH), .KINIT(KINIT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_cos(rsp_cos), .rsp_sin(rsp_sin),
        .core_xin(core_xin), .core_yin(core_yin), .core_zin(core_zin),
        .core_x0(core_x0), .core_y0(core_y0), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] qtrig(input logic [15:0] z, input bit sine);
        real a, v;
        a = real'(int'($signed(z))) / 8192.0;
        v = (sine ? $sin(a) : $cos(a)) * 8192.0;
        return 16'($rtoi(v >= 0.0 ? v + 0.5 : v - 0.5));
    endfunction

    function automatic logic [31:0] core_fn(input logic [47:0] v);
        if (v[47:32] == KINIT && v[31:16] == 16'h0)
            return {qtrig(v[15:0], 1'b0), qtrig(v[15:0], 1'b1)};
        return {v[15:0] ^ 16'h5A5A, 16'hDEAD};
    endfunction

    function automatic logic [15:0] rand_ang();
        return 16'(int'($urandom_range(25736, 0)) - 12868);
    endfunction

    // Core stand-in: fixed-latency pipe that never stalls and is not reset.
    logic [47:0] core_pipe [LAT];
    always @(posedge clk) begin
        core_pipe[0] <= {core_xin, core_yin, core_zin};
        for (int s = 1; s < LAT; s++)
            core_pipe[s] <= core_pipe[s-1];
    end
    assign {core_x0, core_y0} = core_fn(core_pipe[LAT-1]);

    int              n_chk = 0;
    int              n_fail = 0;
    int              cyc = 0;
    int              m_ptr;
    int              m_used [NREQ];
    int              m_head [NREQ];
    int              m_cnt  [NREQ];
    int              m_due  [NREQ][RDEPTH];
    logic [31:0]     m_val  [NREQ][RDEPTH];
    int              n_acc  [NREQ];
    logic [NREQ-1:0] obs_rdy;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int i = 0; i < NREQ; i++) begin
            m_used[i] = 0;
            m_head[i] = 0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic rand_angles();
        for (int i = 0; i < NREQ; i++)
            req_angle[16*i +: 16] = rand_ang();
    endtask

    // One clock: compare outputs with the model, cross the edge, advance model.
    task automatic tick();
        int              g, gi, slot;
        logic [NREQ-1:0] exp_rdy, exp_rv, popm;
        logic [15:0]     ang;
        bit              bz;
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            gi = (m_ptr + k) % NREQ;
            if (g < 0 && req_valid[gi] && m_used[gi] < RDEPTH)
                g = gi;
        end
        exp_rdy = '0;
        ang     = 16'h0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            ang = req_angle[16*g +: 16];
        end
        obs_rdy = req_ready;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("core_xin", 32'(core_xin), 32'((g >= 0) ? KINIT : 16'h0));
        check("core_yin", 32'(core_yin), 32'h0);
        check("core_zin", 32'(core_zin), 32'(ang));
        bz = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            exp_rv[i] = m_cnt[i] > 0 && m_due[i][m_head[i]] <= cyc;
            if (m_used[i] > 0)
                bz = 1'b1;
            if (req_ready[i] && req_valid[i])
                n_acc[i]++;
        end
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("busy", 32'(busy), 32'(bz));
        for (int i = 0; i < NREQ; i++)
            if (exp_rv[i])
                check("rsp_data", {rsp_cos[16*i +: 16], rsp_sin[16*i +: 16]},
                      m_val[i][m_head[i]]);
        popm = exp_rv & rsp_ready;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NREQ; i++)
            if (popm[i]) begin
                m_head[i] = (m_head[i] + 1) % RDEPTH;
                m_cnt[i]--;
                m_used[i]--;
            end
        if (g >= 0) begin
            slot = (m_head[g] + m_cnt[g]) % RDEPTH;
            m_val[g][slot] = {qtrig(ang, 1'b0), qtrig(ang, 1'b1)};
            m_due[g][slot] = cyc + LAT;
            m_cnt[g]++;
            m_used[g]++;
            m_ptr = (g + 1) % NREQ;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_rspv"}, 32'(rsp_valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_core"}, {core_xin, core_zin}, 32'h0);
        check({tag, "_yin"}, 32'(core_yin), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          dc, ds;
        logic [3:0]  exp_g;
        rst       = 1'b1;
        req_valid = '0;
        req_angle = '0;
        rsp_ready = '0;
        model_reset();
        for (int i = 0; i < NREQ; i++) n_acc[i] = 0;
        #12;
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        repeat (30) tick();

        rsp_ready = '1;
        req_valid = '1;
        for (int c = 0; c < 40; c++) begin
            rand_angles();
            tick();
            if (c < 8) begin
                exp_g = 4'b0001 << (c % 4);
                check("rr_order", 32'(obs_rdy), 32'(exp_g));
            end
        end
        req_valid = '0;
        repeat (25) tick();

        req_valid = 4'b0001;
        req_angle[15:0] = 16'h10C1;
        tick();
        check("single_acc", 32'(obs_rdy), 32'h1);
        req_valid = '0;
        n = 0;
        while (!rsp_valid[0] && n < 40) begin
            tick();
            n++;
        end
        check("single_latency", n, 17);
        dc = int'($signed(rsp_cos[15:0])) - 32'sh1BB6;
        ds = int'($signed(rsp_sin[15:0])) - 32'sh1000;
        check("cos_pi6", 32'(dc <= 8 && dc >= -8), 32'h1);
        check("sin_pi6", 32'(ds <= 8 && ds >= -8), 32'h1);
        repeat (5) tick();
        check("single_idle", 32'(busy), 32'h0);

        rsp_ready = '0;
        req_valid = 4'b0001;
        n_acc[0] = 0;
        repeat (30) begin
            rand_angles();
            tick();
        end
        check("stall_acc", n_acc[0], 4);
        check("stall_held", 32'(rsp_valid[0]), 32'h1);
        rsp_ready = 4'b0001;
        repeat (4) begin
            rand_angles();
            tick();
        end
        rsp_ready = '0;
        repeat (25) begin
            rand_angles();
            tick();
        end
        check("refill_acc", n_acc[0], 8);

        req_valid = 4'b1000;
        tick();
        req_valid = 4'b0011;
        rsp_ready = 4'b0001;
        tick();
        check("blocked_gnt", 32'(obs_rdy), 32'h2);
        rsp_ready = '0;
        tick();
        check("unblock_gnt", 32'(obs_rdy), 32'h1);

        req_valid = '0;
        rsp_ready = '1;
        repeat (30) tick();

        repeat (300) begin
            req_valid = NREQ'($urandom);
            rsp_ready = NREQ'($urandom);
            rand_angles();
            tick();
        end

        req_valid = '0;
        rsp_ready = '1;
        repeat (30) tick();
        rsp_ready = '0;
        req_valid = '1;
        repeat (8) begin
            rand_angles();
            tick();
        end
        req_valid = 4'b0010;
        repeat (2) tick();
        req_valid = '1;
        #3;
        rst = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();

        req_valid = 4'b0110;
        rand_angles();
        tick();
        check("rst_ptr", 32'(obs_rdy), 32'h2);
        req_valid = 4'b0100;
        tick();
        check("post_rst_acc", 32'(obs_rdy), 32'h4);
        req_valid = '0;
        rsp_ready = '1;
        n = 0;
        while (!rsp_valid[2] && n < 40) begin
            tick();
            n++;
        end
        check("post_rst_latency", n, 17);
        repeat (25) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
